// File: rtl/word_unloader_128.sv
// Captures a DATA_W-bit word in one cycle and streams it out LSB-first as
// CHUNK_W-bit chunks over a valid/ready handshake, pulsing done after the last chunk.
module word_unloader_128 #(
  parameter int DATA_W  = 128,
  parameter int CHUNK_W = 4,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [CHUNK_W-1:0] out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [IDX_W-1:0]   out_idx_o,
  output logic               out_last_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int SEL_W = $clog2(CHUNK_W);
  localparam int OFF_W = IDX_W + SEL_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  shadow_q;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q;
  logic [OFF_W-1:0]   bit_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            shadow_q <= in_data_i;
            idx_q    <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (out_ready_i) begin
            // The final transfer wraps idx to 0 instead of incrementing past the last chunk.
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bit_off = {idx_q, {SEL_W{1'b0}}};

  // Every output below depends only on registered state (rst only gates in_ready).
  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign out_valid_o = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign out_idx_o   = idx_q;
  assign out_last_o  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign out_data_o  = (state_q == SEND) ? shadow_q[bit_off +: CHUNK_W] : '0;
  assign done_o      = done_q;

endmodule

// File: tb/tb_word_unloader_128.sv
// Randomized self-checking bench for word_unloader_128 against a word/chunk-count
// reference model, plus reassembly of streamed chunks into whole words.
module tb_word_unloader_128;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_idx;
  logic         out_last;
  logic         done;
  logic         busy;

  word_unloader_128 dut (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx),
    .out_last_o  (out_last),
    .done_o      (done),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  // Reference model: a held word and how many of its chunks have been sent.
  bit           m_hold = 0;
  logic [127:0] m_word = '0;
  int           m_sent = 0;
  bit           m_done = 0;

  logic [127:0] cap_q[$];
  logic [127:0] recon = '0;
  int           nxfer = 0;
  int           nwords = 0;
  int           ndone_obs = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_hold = 0;
    m_sent = 0;
    m_done = 0;
    if (nxfer != 0 || cap_q.size() > nwords) begin
      if (cap_q.size() > 0) void'(cap_q.pop_back());
    end
    recon = '0;
    nxfer = 0;
  endtask

  task automatic check_outputs();
    logic [127:0] sh;
    logic [3:0]   exp_nib;
    sh      = m_word >> (4 * m_sent);
    exp_nib = m_hold ? sh[3:0] : 4'h0;
    chk("out_valid", out_valid, m_hold);
    chk("busy",      busy,      m_hold);
    chk("in_ready",  in_ready,  !m_hold && !rst);
    chk("out_idx",   out_idx,   m_hold ? m_sent : 0);
    chk("out_last",  out_last,  m_hold && (m_sent == 31));
    chk("out_data",  out_data,  exp_nib);
    chk("done",      done,      m_done);
  endtask

  // Advance one clock: update model from current inputs, collect transfers, check after the edge.
  task automatic tick();
    if (!rst && out_valid && out_ready) begin
      recon = recon | ({124'd0, out_data} << (4 * nxfer));
      nxfer++;
      if (nxfer == 32) begin
        chk("word", recon, (cap_q.size() > 0) ? cap_q.pop_front() : 128'hx);
        nwords++;
        recon = '0;
        nxfer = 0;
      end
    end
    if (rst) begin
      m_hold = 0; m_sent = 0; m_done = 0;
    end else if (m_hold) begin
      m_done = 0;
      if (out_ready) begin
        if (m_sent == 31) begin
          m_hold = 0; m_sent = 0; m_done = 1;
        end else begin
          m_sent++;
        end
      end
    end else begin
      m_done = 0;
      if (in_valid) begin
        m_hold = 1; m_word = in_data; m_sent = 0;
        cap_q.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
    if (done === 1'b1) ndone_obs++;
    check_outputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (m_hold && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", m_hold, 1'b0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check_outputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("in_ready_release", in_ready, 1'b1);

    // Basic unload
    in_data = 128'h0123456789ABCDEF_FEDCBA9876543210; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_chunk", out_data, 4'h0);
    drain(40);
    chk("done_basic", done, 1'b1);
    tick();
    chk("done_once", done, 1'b0);

    // Stall at idx 5 for 4 cycles
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (m_hold && m_sent != 5) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_data", out_data, 4'h5);
      chk("stall_idx", out_idx, 5'd5);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_data", out_data, 4'h6);
    drain(40);

    // Input isolation: second word offered throughout SEND
    in_data = '1; in_valid = 1'b1;
    tick();
    in_data = '0;
    drain(40);
    chk("iso_idle_after_done", in_ready, 1'b1);
    tick();
    chk("iso_second_capture", busy, 1'b1);
    in_valid = 1'b0;
    drain(40);

    // Reset mid-transfer at idx 12
    in_data = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (m_hold && m_sent != 12) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", out_idx, 5'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    tick();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);
    in_data = 128'h1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("word1_chunk0", out_data, 4'h1);
    drain(40);

    // Random words with random backpressure and input noise
    for (int w = 0; w < 20; w++) begin
      int n;
      in_data = rand128(); in_valid = 1'b1; out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("rand_capture", m_hold, 1'b1);
      n = 0;
      while (m_hold && n < 500) begin
        in_data   = rand128();
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("rand_timeout", m_hold, 1'b0);
    end
    in_valid = 1'b0;
    tick();

    chk("words_total", nwords, 25);
    chk("done_total", ndone_obs, 25);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
